// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: latches game event pulses, plays one square-wave note sequence at a time.
// Define SFX_MIC_MIX_EN to mix microphone input samples under the tone.
module sfx_sequencer #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int NOTE_CYCLES     = 5000000,
  parameter int GAP_CYCLES      = 500000,
  parameter int AMPLITUDE       = 10000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  iReq,
  input  logic        iMute,
  input  logic        iAudioOutAllowed,
`ifdef SFX_MIC_MIX_EN
  input  logic [31:0] iMicLeft,
  input  logic [31:0] iMicRight,
  input  logic        iAudioInAvailable,
  output logic        oReadAudioIn,
`endif
  output logic [31:0] oLeftSample,
  output logic [31:0] oRightSample,
  output logic        oWriteAudio,
  output logic        oBusy,
  output logic [1:0]  oActiveId,
  output logic        oDone,
  output logic [1:0]  debug_state
);

  localparam int HP_A4 = CLOCK_FREQUENCY / (2 * 440);
  localparam int HP_C5 = CLOCK_FREQUENCY / (2 * 523);
  localparam int HP_E5 = CLOCK_FREQUENCY / (2 * 659);
  localparam int HP_G5 = CLOCK_FREQUENCY / (2 * 784);
  localparam int HP_A5 = CLOCK_FREQUENCY / (2 * 880);
  localparam int HP_C6 = CLOCK_FREQUENCY / (2 * 1047);

  // A4 is the lowest note, so it sets the half-period counter width.
  localparam int HP_W   = $clog2(HP_A4 + 1);
  localparam int NOTE_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [31:0]       AMP_POS   = 32'(AMPLITUDE);
  localparam logic [31:0]       AMP_NEG   = 32'(-AMPLITUDE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [3:0]        pend, clr;
  logic [1:0]        id_q, id_d, sel_id;
  logic [1:0]        step_q, step_d, step_last;
  logic [NOTE_W-1:0] note_cnt, note_cnt_d;
  logic [HP_W-1:0]   hp_cnt, hp_cnt_d, hp_last;
  logic              phase, phase_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic [31:0]       tone_q;

  function automatic logic [HP_W-1:0] half_period(input logic [1:0] id, input logic [1:0] step);
    int hp;
    case (id)
      2'd0: hp = HP_A4;
      2'd1: hp = HP_A5;
      2'd2: begin
        case (step)
          2'd0:    hp = HP_C5;
          2'd1:    hp = HP_E5;
          2'd2:    hp = HP_G5;
          default: hp = HP_C6;
        endcase
      end
      default: begin
        case (step)
          2'd0:    hp = HP_E5;
          2'd1:    hp = HP_C5;
          default: hp = HP_A4;
        endcase
      end
    endcase
    return HP_W'(hp);
  endfunction

  always_comb begin
    if (pend[3])      sel_id = 2'd3;
    else if (pend[2]) sel_id = 2'd2;
    else if (pend[1]) sel_id = 2'd1;
    else              sel_id = 2'd0;
  end

  always_comb begin
    case (id_q)
      2'd0:    step_last = 2'd0;
      2'd1:    step_last = 2'd1;
      default: step_last = 2'd3;
    endcase
    hp_last = half_period(id_q, step_q) - HP_W'(1);
  end

  always_comb begin
    state_d    = state;
    id_d       = id_q;
    step_d     = step_q;
    note_cnt_d = note_cnt;
    hp_cnt_d   = hp_cnt;
    phase_d    = phase;
    gap_cnt_d  = gap_cnt;
    done_d     = 1'b0;
    clr        = 4'd0;
    case (state)
      IDLE: begin
        if (pend != 4'd0) begin
          state_d     = PLAY;
          id_d        = sel_id;
          step_d      = 2'd0;
          note_cnt_d  = '0;
          hp_cnt_d    = '0;
          phase_d     = 1'b0;
          clr[sel_id] = 1'b1;
        end
      end
      PLAY: begin
        if (hp_cnt == hp_last) begin
          hp_cnt_d = '0;
          phase_d  = ~phase;
        end else begin
          hp_cnt_d = hp_cnt + 1'b1;
        end
        // Every step restarts its tone at phase 0 so each note begins on +AMPLITUDE.
        if (note_cnt == NOTE_LAST) begin
          note_cnt_d = '0;
          hp_cnt_d   = '0;
          phase_d    = 1'b0;
          if (step_q == step_last) begin
            state_d   = GAP;
            gap_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          note_cnt_d = note_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          id_d    = 2'd0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = 2'd0;
      end
    endcase
    // Game over preempts anything else in flight; the dropped effect never reports done.
    if (state != IDLE && pend[3] && id_q != 2'd3) begin
      state_d    = PLAY;
      id_d       = 2'd3;
      step_d     = 2'd0;
      note_cnt_d = '0;
      hp_cnt_d   = '0;
      phase_d    = 1'b0;
      done_d     = 1'b0;
      clr        = 4'b1000;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= 4'd0;
      id_q     <= 2'd0;
      step_q   <= 2'd0;
      note_cnt <= '0;
      hp_cnt   <= '0;
      phase    <= 1'b0;
      gap_cnt  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tone_q   <= 32'd0;
    end else begin
      state    <= state_d;
      pend     <= (pend & ~clr) | iReq;
      id_q     <= id_d;
      step_q   <= step_d;
      note_cnt <= note_cnt_d;
      hp_cnt   <= hp_cnt_d;
      phase    <= phase_d;
      gap_cnt  <= gap_cnt_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
      tone_q   <= (state_d == PLAY && !iMute) ? (phase_d ? AMP_NEG : AMP_POS) : 32'd0;
    end
  end

  // Write strobe: a sample is taken by Audio_Controller in every cycle oWriteAudio is high;
  // the tone never stalls on back-pressure, so skipped writes simply drop samples.
`ifdef SFX_MIC_MIX_EN
  assign oWriteAudio  = iAudioInAvailable & iAudioOutAllowed;
  assign oReadAudioIn = oWriteAudio;
  assign oLeftSample  = iMicLeft + tone_q;
  assign oRightSample = iMicRight + tone_q;
`else
  assign oWriteAudio  = iAudioOutAllowed & ~reset;
  assign oLeftSample  = tone_q;
  assign oRightSample = tone_q;
`endif

  assign oBusy       = busy_q;
  assign oActiveId   = id_q;
  assign oDone       = done_q;
  assign debug_state = state;

endmodule
